// File: rtl/iic_pkg.sv
// Shared definitions for the FIFO-fed I2C write master.
//   state_t       - transaction FSM encoding
//   DIV_DEFAULT   - system clocks per SCL quarter-period (100 kHz SCL at 100 MHz)
//   sat_inc16     - 16-bit increment that sticks at all-ones
package iic_pkg;

    localparam int DIV_DEFAULT = 250;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_BIT   = 3'd4,
        ST_ACK   = 3'd5,
        ST_STOP  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/iic_qtick.sv
// Quarter-period tick generator.
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   en_i    - count enable; while low the counter is held at 0
//   tick_o  - high on the last cycle of each quarter (counter at DIV-1)
//   first_o - high on the first cycle of each quarter (counter at 0)
module iic_qtick
    import iic_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o,
    output logic first_o
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = en_i && (cnt_q == LAST);
    assign first_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/iic_fifo_tx.sv
// I2C write master that drains a TX FIFO as a single transaction.
//   clk, reset          - system clock, asynchronous active-high reset
//   start               - one-cycle request; accepted only when idle and FIFO not empty
//   fifo_dout/empty     - FIFO read data (latency 1) and empty flag
//   fifo_rd_en          - FIFO read strobe, one cycle per byte
//   scl_oe/sda_oe       - open-drain pull-downs (1 = drive low)
//   sda_i               - synchronized SDA line, sampled for ACK
//   busy/done/nack      - status; nack is sticky until the next accepted start
//   byte_count          - bytes ACKed in the current/last transaction (saturating)
// The first byte is preceded by a START; later bytes (including ones that
// arrive while a byte is on the wire) follow without a repeated START.
module iic_fifo_tx
    import iic_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic [15:0] byte_count
);

    state_t      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        started_q, started_d;
    logic        ack_smp_q, ack_smp_d;
    logic        nack_q, nack_d;
    logic [15:0] count_q, count_d;

    logic        tick_en;
    logic        tick;
    logic        qfirst;
    logic        ack_line;

    // Quarters only run while the bus is being driven, so every bus phase
    // starts on a fresh quarter boundary.
    assign tick_en = (state_q == ST_START) || (state_q == ST_BIT) ||
                     (state_q == ST_ACK)   || (state_q == ST_STOP);

    iic_qtick #(.DIV(DIV)) u_qtick (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (tick_en),
        .tick_o  (tick),
        .first_o (qfirst)
    );

    // With DIV=1 the sample cycle and the end-of-quarter cycle coincide,
    // so use the live line in that case.
    assign ack_line = (qtr_q == 2'd3 && qfirst) ? sda_i : ack_smp_q;

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        started_d = started_q;
        ack_smp_d = ack_smp_q;
        nack_d    = nack_q;
        count_d   = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !fifo_empty) begin
                    state_d   = ST_FETCH;
                    started_d = 1'b0;
                    nack_d    = 1'b0;
                    count_d   = '0;
                end
            end
            ST_FETCH: begin
                qtr_d = '0;
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end else begin
                    // Nothing to send: close the bus only if it was opened.
                    state_d = started_q ? ST_STOP : ST_DONE;
                end
            end
            ST_LOAD: begin
                shift_d = fifo_dout;
                bit_d   = '0;
                qtr_d   = '0;
                state_d = started_q ? ST_BIT : ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d     = '0;
                        started_d = 1'b1;
                        state_d   = ST_BIT;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = ST_ACK;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (qtr_q == 2'd3 && qfirst) begin
                    ack_smp_d = sda_i;
                end
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (!ack_line) begin
                            count_d = sat_inc16(count_q);
                            state_d = fifo_empty ? ST_STOP : ST_FETCH;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                started_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            qtr_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            started_q <= 1'b0;
            ack_smp_q <= 1'b0;
            nack_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            started_q <= started_d;
            ack_smp_q <= ack_smp_d;
            nack_q    <= nack_d;
            count_q   <= count_d;
        end
    end

    // Bus drive is decoded straight from the state register so that a reset
    // releases both lines in the cycle it is asserted.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            ST_FETCH, ST_LOAD: begin
                // Between bytes SCL is held low; before the first byte the bus idles.
                scl_oe = started_q;
            end
            ST_START: begin
                sda_oe = 1'b1;
                scl_oe = (qtr_q == 2'd2);
            end
            ST_BIT: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~shift_q[7];
            end
            ST_ACK: begin
                scl_oe = ~qtr_q[1];
            end
            ST_STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = ~qtr_q[1];
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign fifo_rd_en = (state_q == ST_FETCH) && !fifo_empty;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign nack       = nack_q;
    assign byte_count = count_q;

endmodule
